// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit subtractor cells: a half subtractor and a full subtractor made of
// two half subtractors with their borrows ORed together.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);

  // difference and borrow of a - b
  always_comb begin
    d  = a ^ b;
    bo = ~a & b;
  end

endmodule

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs_ab (
    .a  (a),
    .b  (b),
    .d  (d1),
    .bo (b1)
  );

  half_subtractor u_hs_bin (
    .a  (d1),
    .b  (bin),
    .d  (d),
    .bo (b2)
  );

  // at most one stage can borrow, so OR merges them
  always_comb begin
    bout = b1 | b2;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per cycle, LSB first.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; result outputs hold the last difference
// SHIFT | one bit per cycle through the full subtractor, busy=1
// DONE  | one cycle, done=1, diff/borrow valid; start here begins a new op
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-2:0] dsr;
  logic [WIDTH-1:0] dsr_cat;
  logic [CNT_W-1:0] cnt;
  logic             bin;
  logic             d;
  logic             bout;
  logic             load;
  logic             shift_en;
  logic             last_bit;

  full_subtractor u_fs (
    .a    (ra[0]),
    .b    (rb[0]),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  // new bit joins the partial result from the top; dsr keeps bits already done
  always_comb begin
    dsr_cat  = {d, dsr};
    last_bit = (cnt == LAST_CNT);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and Moore outputs; DONE also accepts a back-to-back start
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operand shift registers, borrow flop, counter and result capture;
  // the result is written on the last bit so it is already valid while done=1
  always_ff @(posedge clk) begin
    if (rst) begin
      ra     <= '0;
      rb     <= '0;
      dsr    <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (load) begin
      ra  <= a;
      rb  <= b;
      bin <= 1'b0;
      cnt <= '0;
    end else if (shift_en) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      dsr <= dsr_cat[WIDTH-1:1];
      bin <= bout;
      cnt <= cnt + CNT_W'(1);
      if (last_bit) begin
        diff   <= dsr_cat;
        borrow <= bout;
      end
    end
  end

endmodule
